// File: rtl/rupt_scheduler.sv
// rupt_scheduler
//   Interrupt-priority scheduler for the AGC interrupt chain. Latches rising edges on the ten
//   program-interrupt request lines, offers the highest-priority pending vector to the sequence
//   generator at an instruction boundary, tracks interrupt-in-progress and raises a latched
//   RUPT LOCK alarm when a single rupt service runs too long.
//
// Ports
//   CLOCK     in   system clock, rising edge
//   rst_      in   asynchronous active-low reset
//   RPTIN     in   [9:0] request lines, index = priority (0 highest)
//   GOJAM     in   synchronous restart, overrides every other input
//   INHINT    in   rupts inhibited (level)
//   OVFL      in   accumulator overflow, blocks grant
//   INSTBND   in   instruction-boundary strobe
//   RUPTACK   in   vector accepted by the sequence generator
//   RESUME    in   RESUME executed, ends service
//   ALMRST    in   clears a latched RUPTLOCK
//   RUPTREQ   out  vector offered
//   RUPTADR   out  [11:0] vector address, zero whenever RUPTREQ is low
//   IIP       out  interrupt in progress
//   PEND      out  [9:0] pending-request latches
//   RUPTLOCK  out  rupt-lock alarm, latched
module rupt_scheduler #(
    parameter int unsigned LOCK_LIMIT = 1024
) (
    input  logic        CLOCK,
    input  logic        rst_,
    input  logic [9:0]  RPTIN,
    input  logic        GOJAM,
    input  logic        INHINT,
    input  logic        OVFL,
    input  logic        INSTBND,
    input  logic        RUPTACK,
    input  logic        RESUME,
    input  logic        ALMRST,
    output logic        RUPTREQ,
    output logic [11:0] RUPTADR,
    output logic        IIP,
    output logic [9:0]  PEND,
    output logic        RUPTLOCK
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StOffer   = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    localparam logic [15:0] CntMax = 16'(LOCK_LIMIT - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  samp_q, samp_d;     // RPTIN registered once
    logic [9:0]  prev_q, prev_d;     // previous sample, for 0->1 detection
    logic [9:0]  pend_q, pend_d;
    logic [3:0]  sel_q, sel_d;       // index frozen for the whole offer
    logic        req_q, req_d;
    logic [11:0] adr_q, adr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lock_q, lock_d;

    logic [9:0]  rise;
    logic [9:0]  clr;
    logic [3:0]  sel_n;
    logic        grant;

    always_comb begin
        rise = samp_q & ~prev_q;

        // Lowest set bit wins: scan from the top so lower indices overwrite.
        sel_n = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (pend_q[i]) sel_n = 4'(i);
        end

        grant = INSTBND & ~INHINT & ~OVFL & (|pend_q);

        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        adr_d   = adr_q;
        clr     = 10'd0;

        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StOffer;
                    sel_d   = sel_n;
                    req_d   = 1'b1;
                    adr_d   = 12'o4000 + {6'd0, sel_n + 4'd1, 2'b00};
                end
            end
            StOffer: begin
                // Ack takes precedence over a same-cycle INHINT.
                if (RUPTACK) begin
                    state_d = StService;
                    clr     = 10'd1 << sel_q;
                    req_d   = 1'b0;
                    adr_d   = 12'd0;
                end else if (INHINT) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    adr_d   = 12'd0;
                end
            end
            StService: begin
                if (RESUME) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                adr_d   = 12'd0;
            end
        endcase

        // A new edge on the bit being acknowledged survives the clear.
        pend_d = (pend_q & ~clr) | rise;
        samp_d = RPTIN;
        prev_d = samp_q;

        if (state_d == StService) begin
            if (state_q != StService)  cnt_d = 16'd0;
            else if (cnt_q < CntMax)   cnt_d = cnt_q + 16'd1;
            else                       cnt_d = cnt_q;
        end else begin
            cnt_d = 16'd0;
        end

        // Set on the edge the counter reaches the limit, so the alarm shows in cycle LOCK_LIMIT.
        lock_d = (lock_q & ~ALMRST) | ((state_d == StService) && (cnt_d == CntMax));

        if (GOJAM) begin
            state_d = StIdle;
            sel_d   = 4'd0;
            req_d   = 1'b0;
            adr_d   = 12'd0;
            pend_d  = 10'd0;
            // Lines high during restart count as already seen.
            samp_d  = RPTIN;
            prev_d  = RPTIN;
            cnt_d   = 16'd0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
            samp_q  <= 10'd0;
            prev_q  <= 10'd0;
            pend_q  <= 10'd0;
            sel_q   <= 4'd0;
            req_q   <= 1'b0;
            adr_q   <= 12'd0;
            cnt_q   <= 16'd0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign RUPTREQ  = req_q;
    assign RUPTADR  = adr_q;
    assign IIP      = (state_q == StService);
    assign PEND     = pend_q;
    assign RUPTLOCK = lock_q;

endmodule

// File: tb/tb_rupt_scheduler.sv
module tb_rupt_scheduler;

    logic        CLOCK = 1'b0;
    logic        rst_;
    logic [9:0]  RPTIN;
    logic        GOJAM, INHINT, OVFL, INSTBND, RUPTACK, RESUME, ALMRST;
    logic        RUPTREQ;
    logic [11:0] RUPTADR;
    logic        IIP;
    logic [9:0]  PEND;
    logic        RUPTLOCK;

    int total = 0;
    int bad   = 0;

    rupt_scheduler #(.LOCK_LIMIT(8)) dut (
        .CLOCK    (CLOCK),
        .rst_     (rst_),
        .RPTIN    (RPTIN),
        .GOJAM    (GOJAM),
        .INHINT   (INHINT),
        .OVFL     (OVFL),
        .INSTBND  (INSTBND),
        .RUPTACK  (RUPTACK),
        .RESUME   (RESUME),
        .ALMRST   (ALMRST),
        .RUPTREQ  (RUPTREQ),
        .RUPTADR  (RUPTADR),
        .IIP      (IIP),
        .PEND     (PEND),
        .RUPTLOCK (RUPTLOCK)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    // One-cycle pulse on the given request bits; PEND updates after the second edge.
    task automatic pulse_rpt(input logic [9:0] bits);
        RPTIN = RPTIN | bits;
        tick();
        RPTIN = RPTIN & ~bits;
        tick();
    endtask

    task automatic strobe();
        INSTBND = 1'b1; tick(); INSTBND = 1'b0;
    endtask

    task automatic ack();
        RUPTACK = 1'b1; tick(); RUPTACK = 1'b0;
    endtask

    task automatic resume();
        RESUME = 1'b1; tick(); RESUME = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; RPTIN = '0; GOJAM = 0; INHINT = 0; OVFL = 0;
        INSTBND = 0; RUPTACK = 0; RESUME = 0; ALMRST = 0;
        tick(2);
        total++;
        if ({RUPTREQ, RUPTADR, IIP, PEND, RUPTLOCK} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b adr=%o iip=%b pend=%h lock=%b want all 0",
                     RUPTREQ, RUPTADR, IIP, PEND, RUPTLOCK);
        end
        rst_ = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        pulse_rpt(10'h010);
        total++;
        if (PEND !== 10'h010) begin bad++; $display("FAIL single_pend got %h want 010", PEND); end
        strobe();
        total++;
        if (RUPTREQ !== 1'b1 || RUPTADR !== 12'o4024) begin
            bad++; $display("FAIL single_offer got req=%b adr=%o want 1/4024", RUPTREQ, RUPTADR);
        end
        ack();
        total++;
        if (PEND !== 10'h000 || IIP !== 1'b1 || RUPTREQ !== 1'b0 || RUPTADR !== 12'd0) begin
            bad++; $display("FAIL single_ack got pend=%h iip=%b req=%b adr=%o want 000/1/0/0",
                            PEND, IIP, RUPTREQ, RUPTADR);
        end
        resume();
        total++;
        if (IIP !== 1'b0) begin bad++; $display("FAIL single_resume got iip=%b want 0", IIP); end
    endtask

    task automatic test_priority();
        pulse_rpt(10'h204);
        total++;
        if (PEND !== 10'h204) begin bad++; $display("FAIL prio_pend got %h want 204", PEND); end
        strobe();
        total++;
        if (RUPTADR !== 12'o4014) begin bad++; $display("FAIL prio_first got %o want 4014", RUPTADR); end
        pulse_rpt(10'h001);
        total++;
        if (RUPTREQ !== 1'b1 || RUPTADR !== 12'o4014 || PEND !== 10'h205) begin
            bad++; $display("FAIL prio_freeze got req=%b adr=%o pend=%h want 1/4014/205",
                            RUPTREQ, RUPTADR, PEND);
        end
        ack();
        total++;
        if (PEND !== 10'h201) begin bad++; $display("FAIL prio_clr2 got %h want 201", PEND); end
        resume();
        strobe();
        total++;
        if (RUPTADR !== 12'o4004) begin bad++; $display("FAIL prio_second got %o want 4004", RUPTADR); end
        ack(); resume(); strobe();
        total++;
        if (RUPTADR !== 12'o4050) begin bad++; $display("FAIL prio_third got %o want 4050", RUPTADR); end
        ack(); resume();
        total++;
        if (PEND !== 10'h000) begin bad++; $display("FAIL prio_drain got %h want 000", PEND); end
    endtask

    task automatic test_gating();
        pulse_rpt(10'h008);
        RUPTACK = 1'b1; tick(); RUPTACK = 1'b0;
        total++;
        if (IIP !== 1'b0 || PEND !== 10'h008) begin
            bad++; $display("FAIL stray_ack got iip=%b pend=%h want 0/008", IIP, PEND);
        end
        INHINT = 1'b1; strobe();
        total++;
        if (RUPTREQ !== 1'b0) begin bad++; $display("FAIL gate_inhint got req=%b want 0", RUPTREQ); end
        INHINT = 1'b0; OVFL = 1'b1; strobe();
        total++;
        if (RUPTREQ !== 1'b0) begin bad++; $display("FAIL gate_ovfl got req=%b want 0", RUPTREQ); end
        OVFL = 1'b0; strobe();
        total++;
        if (RUPTREQ !== 1'b1 || RUPTADR !== 12'o4020) begin
            bad++; $display("FAIL gate_clear got req=%b adr=%o want 1/4020", RUPTREQ, RUPTADR);
        end
        resume();
        total++;
        if (RUPTREQ !== 1'b1 || IIP !== 1'b0) begin
            bad++; $display("FAIL stray_resume got req=%b iip=%b want 1/0", RUPTREQ, IIP);
        end
        INHINT = 1'b1; tick();
        total++;
        if (RUPTREQ !== 1'b0 || RUPTADR !== 12'd0 || IIP !== 1'b0 || PEND !== 10'h008) begin
            bad++; $display("FAIL gate_withdraw got req=%b adr=%o iip=%b pend=%h want 0/0/0/008",
                            RUPTREQ, RUPTADR, IIP, PEND);
        end
        INHINT = 1'b0;
        strobe(); ack(); resume();
    endtask

    task automatic test_collision();
        pulse_rpt(10'h020);
        strobe();
        total++;
        if (RUPTADR !== 12'o4030) begin bad++; $display("FAIL coll_offer got %o want 4030", RUPTADR); end
        RPTIN[5] = 1'b1; tick();
        RPTIN[5] = 1'b0; RUPTACK = 1'b1; tick(); RUPTACK = 1'b0;
        total++;
        if (IIP !== 1'b1 || PEND !== 10'h020) begin
            bad++; $display("FAIL coll_setwins got iip=%b pend=%h want 1/020", IIP, PEND);
        end
        resume(); strobe(); ack(); resume();
        total++;
        if (PEND !== 10'h000) begin bad++; $display("FAIL coll_drain got %h want 000", PEND); end
    endtask

    task automatic test_watchdog();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_rpt(10'h040);
            strobe();
            total++;
            if (RUPTADR !== 12'o4034) begin bad++; $display("FAIL wd_offer got %o want 4034", RUPTADR); end
            ack();
            tick(6);
            total++;
            if (IIP !== 1'b1 || RUPTLOCK !== 1'b0) begin
                bad++; $display("FAIL wd_cycle7 pass=%0d got iip=%b lock=%b want 1/0",
                                pass, IIP, RUPTLOCK);
            end
            tick();
            total++;
            if (RUPTLOCK !== 1'b1) begin
                bad++; $display("FAIL wd_cycle8 pass=%0d got lock=%b want 1", pass, RUPTLOCK);
            end
            tick(3);
            resume(); tick(2);
            total++;
            if (IIP !== 1'b0 || RUPTLOCK !== 1'b1) begin
                bad++; $display("FAIL wd_latched got iip=%b lock=%b want 0/1", IIP, RUPTLOCK);
            end
            ALMRST = 1'b1; tick(); ALMRST = 1'b0;
            total++;
            if (RUPTLOCK !== 1'b0) begin bad++; $display("FAIL wd_almrst got lock=%b want 0", RUPTLOCK); end
        end
    endtask

    task automatic test_gojam();
        pulse_rpt(10'h080);
        strobe();
        RPTIN[1] = 1'b1;
        tick(2);
        total++;
        if (RUPTADR !== 12'o4040 || PEND !== 10'h082) begin
            bad++; $display("FAIL gj_pre got adr=%o pend=%h want 4040/082", RUPTADR, PEND);
        end
        GOJAM = 1'b1; tick(); GOJAM = 1'b0;
        total++;
        if (RUPTREQ !== 1'b0 || RUPTADR !== 12'd0 || IIP !== 1'b0 || PEND !== 10'h000) begin
            bad++; $display("FAIL gj_clear got req=%b adr=%o iip=%b pend=%h want 0/0/0/000",
                            RUPTREQ, RUPTADR, IIP, PEND);
        end
        tick(3); strobe();
        total++;
        if (RUPTREQ !== 1'b0 || PEND !== 10'h000) begin
            bad++; $display("FAIL gj_held got req=%b pend=%h want 0/000", RUPTREQ, PEND);
        end
        RPTIN[1] = 1'b0; tick();
        RPTIN[1] = 1'b1; tick(2);
        RPTIN[1] = 1'b0;
        total++;
        if (PEND !== 10'h002) begin bad++; $display("FAIL gj_retoggle got %h want 002", PEND); end
        strobe();
        total++;
        if (RUPTADR !== 12'o4010) begin bad++; $display("FAIL gj_offer got %o want 4010", RUPTADR); end
    endtask

    task automatic test_async_reset();
        ack();
        pulse_rpt(10'h100);
        total++;
        if (IIP !== 1'b1 || PEND !== 10'h100) begin
            bad++; $display("FAIL ar_pre got iip=%b pend=%h want 1/100", IIP, PEND);
        end
        #2 rst_ = 1'b0;
        #1;
        total++;
        if ({RUPTREQ, RUPTADR, IIP, PEND, RUPTLOCK} !== 25'd0) begin
            bad++; $display("FAIL ar_async got req=%b adr=%o iip=%b pend=%h lock=%b want all 0",
                            RUPTREQ, RUPTADR, IIP, PEND, RUPTLOCK);
        end
        tick();
        rst_ = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_gating();
        test_collision();
        test_watchdog();
        test_gojam();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
